// File: rtl/washer_pkg.sv
// washer_pkg: state encoding, error codes, output bundle and phase/temperature
// tables shared by the washer_sequencer slice.
package washer_pkg;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FILL      = 4'd1,
        S_WASH      = 4'd2,
        S_DRAIN     = 4'd3,
        S_SPIN      = 4'd4,
        S_REBALANCE = 4'd5,
        S_PAUSE     = 4'd6,
        S_COMPLETE  = 4'd7,
        S_ERROR     = 4'd8
    } state_t;

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_FILL  = 3'd1;
    localparam logic [2:0] ERR_DRAIN = 3'd2;
    localparam logic [2:0] ERR_VIB   = 3'd3;
    localparam logic [2:0] ERR_DOOR  = 3'd4;

    localparam int RINSE_TICKS = 180;
    localparam int REBAL_TICKS = 10;

    typedef struct packed {
        logic       water_valve;
        logic       heater;
        logic       drum_motor;
        logic       drain_pump;
        logic       door_lock;
        logic       cycle_complete_led;
        logic       error_led;
        logic       paused;
        logic [1:0] spin_sel;
        logic [2:0] error_code;
        logic [3:0] state_out;
    } out_t;

    function automatic int wash_ticks(input logic [1:0] c);
        return c == 2'd0 ? 600 : c == 2'd1 ? 300 : c == 2'd2 ? 900 : 240;
    endfunction

    function automatic int spin_ticks(input logic [1:0] c);
        return c == 2'd0 ? 360 : c == 2'd1 ? 180 : c == 2'd2 ? 480 : 240;
    endfunction

    // Targets on the 10-bit ADC scale; code 11 heats like Cold.
    function automatic int temp_target(input logic [1:0] t);
        return t == 2'd1 ? 300 : t == 2'd2 ? 600 : 100;
    endfunction

endpackage

// File: rtl/washer_tick_gen.sv
// washer_tick_gen: free-running one-cycle tick pulse every TICK_DIV clocks.
module washer_tick_gen #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);
    localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = cnt_q == CW'(TICK_DIV - 1);

    always_comb cnt_d = tick ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;

endmodule

// File: rtl/washer_sequencer.sv
// washer_sequencer: fill / wash+heat / drain / rinse / spin sequencer with pause,
// timeouts, door supervision and safe drain; WASHER_REBALANCE_EN adds spin rebalance retries.
module washer_sequencer
    import washer_pkg::*;
#(
    parameter int ADC_W         = 10,
    parameter int TICK_DIV      = 1,
    parameter int MAX_RINSES    = 3,
    parameter int FILL_LEVEL    = 512,
    parameter int EMPTY_LEVEL   = 8,
    parameter int FILL_TIMEOUT  = 600,
    parameter int DRAIN_TIMEOUT = 300,
    parameter int MAX_REBALANCE = 2,
    parameter int UNLOCK_DELAY  = 5
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               start,
    input  logic                               stop,
    input  logic [1:0]                         wash_cycle,
    input  logic [1:0]                         temperature,
    input  logic [1:0]                         spin_speed,
    input  logic [$clog2(MAX_RINSES+1)-1:0]    rinse_count,
    input  logic                               door_locked,
    input  logic [ADC_W-1:0]                   water_level,
    input  logic [ADC_W-1:0]                   temperature_adc,
    input  logic                               vibration_sensor,
    output logic                               water_valve,
    output logic                               heater,
    output logic                               drum_motor,
    output logic                               drain_pump,
    output logic                               door_lock,
    output logic                               cycle_complete_led,
    output logic                               error_led,
    output logic                               paused,
    output logic [1:0]                         spin_sel,
    output logic [2:0]                         error_code,
    output logic [3:0]                         state_out
);
    localparam int SH   = ADC_W - 10;
    localparam int RC_W = $clog2(MAX_RINSES + 1);
    localparam logic [ADC_W-1:0] FILL_TH  = ADC_W'(FILL_LEVEL << SH);
    localparam logic [ADC_W-1:0] EMPTY_TH = ADC_W'(EMPTY_LEVEL << SH);
    localparam logic [RC_W-1:0]  RC_MAX   = RC_W'(MAX_RINSES);
`ifdef WASHER_REBALANCE_EN
    localparam int RB_W = MAX_REBALANCE > 0 ? $clog2(MAX_REBALANCE + 1) : 1;
    logic [RB_W-1:0] retry_q, retry_d;
`endif

    state_t          state_q, state_d, saved_q, saved_d;
    logic [1:0]      cyc_q, cyc_d, temp_q, temp_d, spin_q, spin_d;
    logic [RC_W-1:0] rinses_q, rinses_d, rinse_done_q, rinse_done_d;
    logic [2:0]      err_q, err_d;
    logic [15:0]     timer_q, timer_d;
    out_t            out_q, out_d;
    logic            tick, phase, active, empty;
    logic [31:0]     tcount, wash_dur, spin_dur;
    logic [ADC_W-1:0] temp_th;

    washer_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (.clk(clk), .reset_n(reset_n), .tick(tick));

    assign tcount   = 32'(timer_q) + 32'd1;
    assign wash_dur = rinse_done_q != '0 ? 32'(RINSE_TICKS) : 32'(wash_ticks(cyc_q));
    assign spin_dur = 32'(spin_ticks(cyc_q));
    assign temp_th  = ADC_W'(temp_target(temp_q) << SH);
    assign empty    = water_level <= EMPTY_TH;
    assign phase    = state_q inside {S_FILL, S_WASH, S_DRAIN, S_SPIN, S_REBALANCE};
    assign active   = phase || state_q == S_PAUSE;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            saved_q      <= S_IDLE;
            cyc_q        <= '0;
            temp_q       <= '0;
            spin_q       <= '0;
            rinses_q     <= '0;
            rinse_done_q <= '0;
            err_q        <= ERR_NONE;
            timer_q      <= '0;
            out_q        <= '0;
`ifdef WASHER_REBALANCE_EN
            retry_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            saved_q      <= saved_d;
            cyc_q        <= cyc_d;
            temp_q       <= temp_d;
            spin_q       <= spin_d;
            rinses_q     <= rinses_d;
            rinse_done_q <= rinse_done_d;
            err_q        <= err_d;
            timer_q      <= timer_d;
            out_q        <= out_d;
`ifdef WASHER_REBALANCE_EN
            retry_q      <= retry_d;
`endif
        end
    end

    // Faults are decided inside the case; normal exits wait for !stop so a
    // simultaneous stop pauses in the old state.
    always_comb begin
        state_d      = state_q;
        saved_d      = saved_q;
        cyc_d        = cyc_q;
        temp_d       = temp_q;
        spin_d       = spin_q;
        rinses_d     = rinses_q;
        rinse_done_d = rinse_done_q;
        err_d        = err_q;
`ifdef WASHER_REBALANCE_EN
        retry_d      = retry_q;
`endif
        case (state_q)
            S_IDLE: if (start && door_locked) begin
                state_d      = S_FILL;
                cyc_d        = wash_cycle;
                temp_d       = temperature;
                spin_d       = spin_speed;
                rinses_d     = rinse_count > RC_MAX ? RC_MAX : rinse_count;
                rinse_done_d = '0;
                err_d        = ERR_NONE;
`ifdef WASHER_REBALANCE_EN
                retry_d      = '0;
`endif
            end
            S_FILL: if (tick && tcount == 32'(FILL_TIMEOUT)) begin
                state_d = S_ERROR;
                err_d   = ERR_FILL;
            end else if (!stop && water_level >= FILL_TH) state_d = S_WASH;
            S_WASH: if (!stop && tick && tcount == wash_dur) state_d = S_DRAIN;
            S_DRAIN: if (tick && tcount == 32'(DRAIN_TIMEOUT)) begin
                state_d = S_ERROR;
                err_d   = ERR_DRAIN;
            end else if (!stop && empty) begin
                state_d      = rinse_done_q < rinses_q ? S_FILL : S_SPIN;
                rinse_done_d = rinse_done_q < rinses_q ? rinse_done_q + 1'b1 : rinse_done_q;
            end
            S_SPIN: if (vibration_sensor) begin
`ifdef WASHER_REBALANCE_EN
                if (retry_q < RB_W'(MAX_REBALANCE)) begin
                    state_d = S_REBALANCE;
                    retry_d = retry_q + 1'b1;
                end else begin
                    state_d = S_ERROR;
                    err_d   = ERR_VIB;
                end
`else
                state_d = S_ERROR;
                err_d   = ERR_VIB;
`endif
            end else if (!stop && tick && tcount == spin_dur) state_d = S_COMPLETE;
`ifdef WASHER_REBALANCE_EN
            S_REBALANCE: if (!stop && tick && tcount == 32'(REBAL_TICKS)) state_d = S_SPIN;
`endif
            S_PAUSE:    if (start) state_d = saved_q;
            S_COMPLETE: if (tick && tcount == 32'(UNLOCK_DELAY)) state_d = S_IDLE;
            S_ERROR:    if (start && empty) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
        if (active && !door_locked) begin
            state_d = S_ERROR;
            err_d   = ERR_DOOR;
        end else if (stop && phase && state_d == state_q) begin
            state_d = S_PAUSE;
            saved_d = state_q;
        end
        // Entering or leaving PAUSE keeps the count so a resumed phase continues.
        timer_d = state_d != state_q ? ((state_d == S_PAUSE || state_q == S_PAUSE) ? timer_q : '0)
                : (tick && state_q != S_PAUSE && timer_q != '1) ? timer_q + 1'b1 : timer_q;
    end

    always_comb begin
        out_d                    = '0;
        out_d.state_out          = state_q;
        out_d.spin_sel           = spin_q;
        out_d.error_code         = err_q;
        out_d.water_valve        = state_q == S_FILL;
        out_d.heater             = state_q == S_WASH && rinse_done_q == '0 && temperature_adc < temp_th;
        out_d.drum_motor         = state_q inside {S_WASH, S_SPIN};
        out_d.drain_pump         = state_q inside {S_DRAIN, S_SPIN} || (state_q == S_ERROR && !empty);
        out_d.door_lock          = state_q != S_IDLE && !(state_q == S_ERROR && empty);
        out_d.cycle_complete_led = state_q == S_COMPLETE;
        out_d.error_led          = state_q == S_ERROR;
        out_d.paused             = state_q == S_PAUSE;
    end

    assign water_valve        = out_q.water_valve;
    assign heater             = out_q.heater;
    assign drum_motor         = out_q.drum_motor;
    assign drain_pump         = out_q.drain_pump;
    assign door_lock          = out_q.door_lock;
    assign cycle_complete_led = out_q.cycle_complete_led;
    assign error_led          = out_q.error_led;
    assign paused             = out_q.paused;
    assign spin_sel           = out_q.spin_sel;
    assign error_code         = out_q.error_code;
    assign state_out          = out_q.state_out;

endmodule

// File: tb/tb_washer_sequencer.sv
// tb_washer_sequencer: table-driven full-cycle check plus directed corner sequences.
module tb_washer_sequencer;
    logic       clk = 1'b0, reset_n = 1'b0, start = 1'b0, stop = 1'b0;
    logic [1:0] wash_cycle = '0, temperature = '0, spin_speed = '0, rinse_count = '0;
    logic       door_locked = 1'b0, vibration_sensor = 1'b0;
    logic [9:0] water_level = '0, temperature_adc = '0;
    logic       water_valve, heater, drum_motor, drain_pump, door_lock;
    logic       cycle_complete_led, error_led, paused;
    logic [1:0] spin_sel;
    logic [2:0] error_code;
    logic [3:0] state_out;
    int checks = 0, passes = 0;

    typedef struct {
        logic        start;
        logic [9:0]  lvl;
        logic [9:0]  tadc;
        int          n;
        logic [14:0] exp;
    } vec_t;
    vec_t tab[18];

    washer_sequencer dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
        .wash_cycle(wash_cycle), .temperature(temperature), .spin_speed(spin_speed),
        .rinse_count(rinse_count), .door_locked(door_locked), .water_level(water_level),
        .temperature_adc(temperature_adc), .vibration_sensor(vibration_sensor),
        .water_valve(water_valve), .heater(heater), .drum_motor(drum_motor),
        .drain_pump(drain_pump), .door_lock(door_lock),
        .cycle_complete_led(cycle_complete_led), .error_led(error_led), .paused(paused),
        .spin_sel(spin_sel), .error_code(error_code), .state_out(state_out)
    );

    always #5 clk = ~clk;

    // Expected vector: {state, valve heater motor pump lock, complete error paused, error_code}
    function automatic logic [14:0] ex(input logic [3:0] st, input logic [4:0] act,
                                       input logic [2:0] led, input logic [2:0] err);
        return {st, act, led, err};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [14:0] exp);
        logic [14:0] act;
        act = {state_out, water_valve, heater, drum_motor, drain_pump, door_lock,
               cycle_complete_led, error_led, paused, error_code};
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic check_sel(input string nm, input logic [1:0] exp);
        checks++;
        if (spin_sel === exp) passes++;
        else $display("FAIL %s: spin_sel got %0d expected %0d", nm, spin_sel, exp);
    endtask

    task automatic launch(input logic [1:0] wc, input logic [1:0] tp, input logic [1:0] sp,
                          input logic [1:0] rc, input logic [9:0] l);
        wash_cycle = wc; temperature = tp; spin_speed = sp; rinse_count = rc;
        water_level = l; door_locked = 1'b1; start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    // Quick cycle, no rinse: ends with outputs showing the first SPIN cycle.
    task automatic to_spin(input logic [1:0] sp);
        launch(2'd3, 2'd0, sp, 2'd0, 10'd600);
        cyc(1);
        water_level = 10'd0;
        cyc(242);
    endtask

    initial begin
        #12;
        check("reset", ex(4'd0, 5'b00000, 3'b000, 3'd0));
        check_sel("reset_sel", 2'd0);
        reset_n = 1'b1;
        tab[0]  = '{1'b1, 10'd0,   10'd0,   2,   ex(4'd1, 5'b10001, 3'b000, 3'd0)};
        tab[1]  = '{1'b0, 10'd0,   10'd0,   10,  ex(4'd1, 5'b10001, 3'b000, 3'd0)};
        tab[2]  = '{1'b0, 10'd600, 10'd0,   2,   ex(4'd2, 5'b01101, 3'b000, 3'd0)};
        tab[3]  = '{1'b0, 10'd600, 10'd700, 1,   ex(4'd2, 5'b00101, 3'b000, 3'd0)};
        tab[4]  = '{1'b0, 10'd600, 10'd500, 597, ex(4'd2, 5'b01101, 3'b000, 3'd0)};
        tab[5]  = '{1'b0, 10'd600, 10'd500, 1,   ex(4'd2, 5'b01101, 3'b000, 3'd0)};
        tab[6]  = '{1'b0, 10'd600, 10'd500, 1,   ex(4'd3, 5'b00011, 3'b000, 3'd0)};
        tab[7]  = '{1'b0, 10'd0,   10'd0,   2,   ex(4'd1, 5'b10001, 3'b000, 3'd0)};
        tab[8]  = '{1'b0, 10'd600, 10'd0,   2,   ex(4'd2, 5'b00101, 3'b000, 3'd0)};
        tab[9]  = '{1'b0, 10'd600, 10'd0,   178, ex(4'd2, 5'b00101, 3'b000, 3'd0)};
        tab[10] = '{1'b0, 10'd600, 10'd0,   1,   ex(4'd2, 5'b00101, 3'b000, 3'd0)};
        tab[11] = '{1'b0, 10'd600, 10'd0,   1,   ex(4'd3, 5'b00011, 3'b000, 3'd0)};
        tab[12] = '{1'b0, 10'd0,   10'd0,   2,   ex(4'd4, 5'b00111, 3'b000, 3'd0)};
        tab[13] = '{1'b0, 10'd0,   10'd0,   358, ex(4'd4, 5'b00111, 3'b000, 3'd0)};
        tab[14] = '{1'b0, 10'd0,   10'd0,   1,   ex(4'd4, 5'b00111, 3'b000, 3'd0)};
        tab[15] = '{1'b0, 10'd0,   10'd0,   1,   ex(4'd7, 5'b00001, 3'b100, 3'd0)};
        tab[16] = '{1'b0, 10'd0,   10'd0,   4,   ex(4'd7, 5'b00001, 3'b100, 3'd0)};
        tab[17] = '{1'b0, 10'd0,   10'd0,   1,   ex(4'd0, 5'b00000, 3'b000, 3'd0)};
        wash_cycle = 2'd0; temperature = 2'd2; spin_speed = 2'd1; rinse_count = 2'd1;
        door_locked = 1'b1;
        for (int i = 0; i < 18; i++) begin
            start = tab[i].start; water_level = tab[i].lvl; temperature_adc = tab[i].tadc;
            cyc(tab[i].n);
            check($sformatf("full_cycle[%0d]", i), tab[i].exp);
        end
        start = 1'b0;
        check_sel("full_cycle_sel", 2'd1);

        launch(2'd0, 2'd0, 2'd0, 2'd0, 10'd100);
        cyc(600);
        check("fill_before_timeout", ex(4'd1, 5'b10001, 3'b000, 3'd0));
        water_level = 10'd0;
        cyc(1);
        check("fill_timeout", ex(4'd8, 5'b00000, 3'b010, 3'd1));
        start = 1'b1; cyc(1); start = 1'b0; cyc(1);
        check("fill_err_clear", ex(4'd0, 5'b00000, 3'b000, 3'd1));

        to_spin(2'd2);
        check("vib_spin", ex(4'd4, 5'b00111, 3'b000, 3'd0));
`ifdef WASHER_REBALANCE_EN
        vibration_sensor = 1'b1; cyc(1); vibration_sensor = 1'b0; cyc(1);
        check("rebal1", ex(4'd5, 5'b00001, 3'b000, 3'd0));
        cyc(9);
        check("rebal1_last", ex(4'd5, 5'b00001, 3'b000, 3'd0));
        cyc(1);
        check("respin1", ex(4'd4, 5'b00111, 3'b000, 3'd0));
        vibration_sensor = 1'b1; cyc(1); vibration_sensor = 1'b0; cyc(10);
        check("rebal2_last", ex(4'd5, 5'b00001, 3'b000, 3'd0));
        cyc(1);
        check("respin2", ex(4'd4, 5'b00111, 3'b000, 3'd0));
`endif
        vibration_sensor = 1'b1; cyc(1); vibration_sensor = 1'b0; cyc(1);
        check("vib_error", ex(4'd8, 5'b00000, 3'b010, 3'd3));
        start = 1'b1; cyc(1); start = 1'b0; cyc(1);
        check("vib_clear", ex(4'd0, 5'b00000, 3'b000, 3'd3));

        temperature_adc = 10'd200;
        launch(2'd0, 2'd0, 2'd0, 2'd0, 10'd600);
        cyc(201);
        stop = 1'b1; cyc(1); stop = 1'b0; cyc(1);
        check("paused", ex(4'd6, 5'b00001, 3'b001, 3'd0));
        cyc(48);
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(400);
        check("resumed_wash_last", ex(4'd2, 5'b00101, 3'b000, 3'd0));
        cyc(1);
        check("resumed_wash_done", ex(4'd3, 5'b00011, 3'b000, 3'd0));

        door_locked = 1'b0; water_level = 10'd300; cyc(1); door_locked = 1'b1; cyc(1);
        check("door_error", ex(4'd8, 5'b00011, 3'b010, 3'd4));
        start = 1'b1; cyc(1); start = 1'b0; cyc(3);
        check("door_error_not_empty", ex(4'd8, 5'b00011, 3'b010, 3'd4));
        water_level = 10'd8; cyc(1);
        check("door_error_empty", ex(4'd8, 5'b00000, 3'b010, 3'd4));
        start = 1'b1; cyc(1); start = 1'b0; cyc(1);
        check("door_clear", ex(4'd0, 5'b00000, 3'b000, 3'd4));

        to_spin(2'd2);
        spin_speed = 2'd1;
        check("spin_before_reset", ex(4'd4, 5'b00111, 3'b000, 3'd0));
        check_sel("spin_sel_latched", 2'd2);
        #3 reset_n = 1'b0;
        #1;
        check("async_reset", ex(4'd0, 5'b00000, 3'b000, 3'd0));
        check_sel("async_reset_sel", 2'd0);
        reset_n = 1'b1;
        cyc(1);
        check("after_reset", ex(4'd0, 5'b00000, 3'b000, 3'd0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
